// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: load/store port of the data memory.
// The master drives the request fields and the slave returns ready, rvalid, rdata and err.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, size, unsigned_ld, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data memory with lane-merged stores, extended loads, fault flags and display taps.
// Defining DMEM_INIT_EN adds an INIT state that preloads words 0..3 after reset.
module dmem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 'h1000,
    parameter int NUM_TAPS  = 4,
    parameter int TAP_IDX   = 1015,
    parameter int TAP_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    dmem_ctrl_if.slave                bus,
    output logic                      init_busy,
    output logic [NUM_TAPS*TAP_W-1:0] taps
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LO = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] HI = LO + (ADDR_W+1)'(4 * DEPTH);

`ifdef DMEM_INIT_EN
    typedef enum logic {INIT, IDLE} state_t;
`else
    typedef enum logic {IDLE} state_t;
`endif

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             hit;
    logic             fault;
    logic             accept;
    logic             st_we;
    logic             init_we;
    logic [IDX_W-1:0] init_idx;
    logic [31:0]      init_val;
    logic [31:0]      word;
    logic [31:0]      merged;
    logic [31:0]      mem [DEPTH];

    assign hit    = ({1'b0, bus.addr} >= LO) && ({1'b0, bus.addr} < HI);
    assign idx    = IDX_W'((bus.addr - LO[ADDR_W-1:0]) >> 2);
    assign lane   = bus.addr[1:0];
    assign word   = mem[idx];
    assign fault  = !hit || (bus.size == 2'b11)
                  || (bus.size == 2'b01 && lane[0])
                  || (bus.size == 2'b10 && lane != 2'b00);
    assign accept = bus.req && bus.ready;
    assign st_we  = accept && bus.we && !fault && !reset;

    // Half-word lanes are 0 or 2 once alignment passes, so lane[1] picks the half.
    always_comb begin
        merged = word;
        unique case (bus.size)
            2'b00:   merged[{lane, 3'b000} +: 8] = bus.wdata[7:0];
            2'b01:   merged[{lane[1], 4'b0000} +: 16] = bus.wdata[15:0];
            default: merged = bus.wdata;
        endcase
    end

    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [1:0]  ln,
        input logic [1:0]  sz,
        input logic        u
    );
        logic [31:0] s;
        s = w >> {ln, 3'b000};
        unique case (sz)
            2'b00:   extract = u ? {24'd0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            2'b01:   extract = u ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: extract = s;
        endcase
    endfunction

`ifdef DMEM_INIT_EN
    logic [1:0] cnt;

    assign init_we  = (state == INIT) && !reset;
    assign init_idx = IDX_W'(cnt);

    always_comb begin
        init_val = 32'd0;
        unique case (cnt)
            2'd0:    init_val = 32'd4;
            2'd1:    init_val = 32'd2;
            2'd2:    init_val = 32'd1;
            default: init_val = 32'd3;
        endcase
    end
`else
    assign init_we  = 1'b0;
    assign init_idx = '0;
    assign init_val = '0;
`endif

    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_idx] <= init_val;
        else if (st_we)
            mem[idx] <= merged;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef DMEM_INIT_EN
            state     <= INIT;
            bus.ready <= 1'b0;
            init_busy <= 1'b1;
            cnt       <= 2'd0;
`else
            state     <= IDLE;
            bus.ready <= 1'b1;
            init_busy <= 1'b0;
`endif
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            bus.rdata  <= 32'd0;
            taps       <= '0;
        end else begin
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            unique case (state)
`ifdef DMEM_INIT_EN
                INIT: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state     <= IDLE;
                        bus.ready <= 1'b1;
                        init_busy <= 1'b0;
                    end
                end
`endif
                IDLE: begin
                    if (accept) begin
                        bus.err <= fault;
                        if (!bus.we) begin
                            bus.rvalid <= 1'b1;
                            bus.rdata  <= fault ? 32'd0
                                : extract(word, lane, bus.size, bus.unsigned_ld);
                        end else if (!fault) begin
                            for (int i = 0; i < NUM_TAPS; i++)
                                if (idx == IDX_W'(TAP_IDX + i))
                                    taps[i*TAP_W +: TAP_W] <= merged[TAP_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
